mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single cache-line memory bus (mem_bus_req_t / mem_bus_resp_t, 58-bit line address, 512-bit line data) between the instruction-fetch cache port (IF) and the data cache port (MEM).
- Sits between the two L1 caches and the memory/bus model.
- Round-robin, one outstanding transaction at a time, with a request latch, ownership tracking and a watchdog.

Parameters:
- TIMEOUT_CYCLES, 1024: BUSY cycles without mem_ready before timeout_err sets; 0 disables the watchdog.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- if_req  in  572  mem_bus_req_t from the IF cache.
- if_resp  out  513  mem_bus_resp_t to the IF cache.
- mem_req_in  in  572  mem_bus_req_t from the MEM (data) cache.
- mem_resp_out  out  513  mem_bus_resp_t to the MEM cache.
- bus_req  out  572  mem_bus_req_t to the memory bus (registered).
- bus_resp  in  513  mem_bus_resp_t from the memory bus.
- owner  out  2  mem_owner_t: OWNER_NONE / OWNER_IF / OWNER_MEM.
- timeout_err  out  1  sticky: watchdog expired.
- proto_err  out  1  sticky: a requester asserted load and store together.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values, applied immediately and asynchronously, including mid-transaction:
  - state = IDLE; bus_req = all zero; owner = OWNER_NONE.
  - if_resp and mem_resp_out = zero.
  - last_owner = OWNER_IF, so MEM wins the first tie.
  - timeout_err = 0; proto_err = 0; watchdog count = 0.
- Pending requester: mem_req_load | mem_req_store is set. Requests are level signals; a requester holds its request until it sees its own mem_ready.
- State IDLE:
  - No pending requester: stay in IDLE.
  - One requester pending: grant it.
  - Both pending: grant the one that is not last_owner.
  - At the clock edge, the granted request (addr, data_out, load, store) is latched into bus_req, owner is set, and state moves to BUSY_IF or BUSY_MEM.
  - Load and store both set: latch as store only (load = 0) and set proto_err.
- State BUSY_x:
  - bus_req is held from the latched copy; requester changes during BUSY are ignored.
  - When bus_resp.mem_ready = 1, in the same cycle (combinational): x_resp.mem_ready = 1 and x_resp.mem_data = bus_resp.mem_data.
  - At the next edge: bus_req cleared to zero, last_owner = x, owner = NONE, state = IDLE.
- Non-owner response: always mem_ready = 0 and mem_data = 0. In IDLE, both responses are zero and bus_resp is ignored.
- Latency:
  - Request first seen in IDLE at cycle t -> bus_req valid at t+1.
  - mem_ready at cycle k -> owner sees ready at k.
  - Mandatory IDLE turnaround at k+1; next bus_req earliest at k+2.
  - A requester still asserting at k+1 is treated as a new request, which allows back-to-back transactions.
- Fairness: with both requesters continuously pending, grants alternate strictly.
- Watchdog:
  - Counter counts BUSY cycles and clears on entry to BUSY.
  - When count reaches TIMEOUT_CYCLES, timeout_err sets (sticky until reset).
  - The transaction keeps waiting; there is no abort.
  - The counter saturates and does not wrap.
- mem_ready arriving on the very first BUSY cycle is legal (1-cycle memory).

Decomposition:
- Add to the structures package:
  - mem_owner_t enum (OWNER_NONE = 0, OWNER_IF, OWNER_MEM).
  - mem_arb_state_t enum (ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_MEM).
- Reuse mem_bus_req_t and mem_bus_resp_t unchanged.
- One natural sub-module, mem_bus_watchdog: a saturating counter with clear, enable and TIMEOUT_CYCLES compare, producing a sticky flag.

Test Plan:
- Reset, then IF load to addr 0x000_0040: bus_req valid the next cycle with load = 1, addr = 0x40. Memory returns ready with data 0xA5... after 3 cycles -> if_resp.mem_ready pulses for 1 cycle with that data, mem_resp_out stays 0, bus_req is zero the following cycle.
- IF and MEM request in the same IDLE cycle directly after reset -> MEM is granted first, IF second. With both held continuously for 6 transactions, the grant order is MEM, IF, MEM, IF, MEM, IF.
- MEM store to addr 0x10 with data pattern D while IF changes its address mid-BUSY -> bus_req stays at addr 0x10 and data D until ready. The IF request is then served with its current address.
- 1-cycle memory (ready on the first BUSY cycle) with IF held high -> the IF bus_req pattern is valid 1 cycle, zero 1 cycle, repeating. No ready is ever delivered to MEM.
- TIMEOUT_CYCLES = 8, memory never readies -> timeout_err rises after 8 BUSY cycles and stays high. bus_req stays held. A later ready completes normally.
- Reset asserted mid-BUSY (asynchronously, between clock edges) -> bus_req and owner clear immediately without waiting for a clock edge. MEM sends load = store = 1 after reset release -> bus_req.store = 1, load = 0, proto_err = 1.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared cache-line bus structures plus arbiter ownership/state encodings.
package mem_bus_arbiter_pkg;

    typedef struct packed {
        logic [57:0]  mem_addr;
        logic [511:0] mem_data_out;
        logic         mem_req_load;
        logic         mem_req_store;
    } mem_bus_req_t;

    typedef struct packed {
        logic [511:0] mem_data;
        logic         mem_ready;
    } mem_bus_resp_t;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_MEM  = 2'd2
    } mem_owner_t;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_IF  = 2'd1,
        ARB_BUSY_MEM = 2'd2
    } mem_arb_state_t;

    function automatic logic req_pending(input mem_bus_req_t r);
        return r.mem_req_load | r.mem_req_store;
    endfunction

    function automatic logic req_conflict(input mem_bus_req_t r);
        return r.mem_req_load & r.mem_req_store;
    endfunction

    // A request with both load and store set goes to the bus as a store.
    function automatic mem_bus_req_t sanitize_req(input mem_bus_req_t r);
        mem_bus_req_t s;
        s = r;
        if (req_conflict(r)) begin
            s.mem_req_load = 1'b0;
        end else begin
            s.mem_req_load = r.mem_req_load;
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_bus_watchdog.sv
// Saturating BUSY-cycle counter raising a sticky flag at TIMEOUT_CYCLES (0 disables).
module mem_bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;

    // Next count and sticky flag.
    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (clear_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (enable_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
        if ((TIMEOUT_CYCLES != 32'd0) && enable_i && !clear_i && (cnt_d == LIMIT)) begin
            flag_d = 1'b1;
        end else begin
            flag_d = flag_q;
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= {CNT_W{1'b0}};
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign expired_o = flag_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one cache-line memory bus between the IF and MEM caches,
// one outstanding transaction at a time.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic          clock,
    input  logic          reset,
    input  mem_bus_req_t  if_req,
    output mem_bus_resp_t if_resp,
    input  mem_bus_req_t  mem_req_in,
    output mem_bus_resp_t mem_resp_out,
    output mem_bus_req_t  bus_req,
    input  mem_bus_resp_t bus_resp,
    output mem_owner_t    owner,
    output logic          timeout_err,
    output logic          proto_err
);

    mem_arb_state_t state_q, state_d;
    mem_bus_req_t   bus_req_q, bus_req_d;
    mem_owner_t     owner_q, owner_d;
    mem_owner_t     last_owner_q, last_owner_d;
    logic           proto_err_q, proto_err_d;
    logic           grant_mem_s, grant_if_s;
    logic           wd_clear_s, wd_enable_s;

    // MEM wins a tie unless it owned the bus last.
    assign grant_mem_s = req_pending(mem_req_in) &&
                         (!req_pending(if_req) || (last_owner_q == OWNER_IF));
    assign grant_if_s  = req_pending(if_req) && !grant_mem_s;

    // Arbitration and transaction-completion next state.
    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        proto_err_d  = proto_err_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_mem_s) begin
                    bus_req_d   = sanitize_req(mem_req_in);
                    owner_d     = OWNER_MEM;
                    state_d     = ARB_BUSY_MEM;
                    proto_err_d = proto_err_q | req_conflict(mem_req_in);
                end else if (grant_if_s) begin
                    bus_req_d   = sanitize_req(if_req);
                    owner_d     = OWNER_IF;
                    state_d     = ARB_BUSY_IF;
                    proto_err_d = proto_err_q | req_conflict(if_req);
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY_IF, ARB_BUSY_MEM: begin
                if (bus_resp.mem_ready) begin
                    bus_req_d    = '0;
                    owner_d      = OWNER_NONE;
                    state_d      = ARB_IDLE;
                    last_owner_d = (state_q == ARB_BUSY_IF) ? OWNER_IF : OWNER_MEM;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                bus_req_d = '0;
                owner_d   = OWNER_NONE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            bus_req_q    <= '0;
            owner_q      <= OWNER_NONE;
            last_owner_q <= OWNER_IF;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Same-cycle response routing to the current owner only.
    always_comb begin
        if_resp      = '0;
        mem_resp_out = '0;
        if ((state_q == ARB_BUSY_IF) && bus_resp.mem_ready) begin
            if_resp = bus_resp;
        end else if ((state_q == ARB_BUSY_MEM) && bus_resp.mem_ready) begin
            mem_resp_out = bus_resp;
        end else begin
            if_resp      = '0;
            mem_resp_out = '0;
        end
    end

    assign wd_clear_s  = (state_q == ARB_IDLE);
    assign wd_enable_s = (state_q != ARB_IDLE) && !bus_resp.mem_ready;

    mem_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (wd_clear_s),
        .enable_i (wd_enable_s),
        .expired_o(timeout_err)
    );

    assign bus_req   = bus_req_q;
    assign owner     = owner_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (watchdog shortened to 8 cycles).
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    mem_bus_req_t  if_req, mem_req_in, bus_req;
    mem_bus_resp_t if_resp, mem_resp_out, bus_resp;
    mem_owner_t    owner;
    logic          timeout_err, proto_err;
    int            total = 0;
    int            bad   = 0;

    mem_bus_req_t  rq_if, rq_mem;
    logic [511:0]  dpat;

    always #5 clock = ~clock;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .if_req      (if_req),
        .if_resp     (if_resp),
        .mem_req_in  (mem_req_in),
        .mem_resp_out(mem_resp_out),
        .bus_req     (bus_req),
        .bus_resp    (bus_resp),
        .owner       (owner),
        .timeout_err (timeout_err),
        .proto_err   (proto_err)
    );

    function automatic mem_bus_req_t mkreq(input logic [57:0] a, input logic [511:0] d,
                                           input logic ld, input logic st);
        mem_bus_req_t r;
        r.mem_addr      = a;
        r.mem_data_out  = d;
        r.mem_req_load  = ld;
        r.mem_req_store = st;
        return r;
    endfunction

    function automatic mem_bus_resp_t mkresp(input logic [511:0] d, input logic rdy);
        mem_bus_resp_t r;
        r.mem_data  = d;
        r.mem_ready = rdy;
        return r;
    endfunction

    task automatic chk_req(input string tag, input mem_bus_req_t obs, input mem_bus_req_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input mem_bus_resp_t obs, input mem_bus_resp_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_own(input string tag, input mem_owner_t obs, input mem_owner_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        if_req     = '0;
        mem_req_in = '0;
        bus_resp   = '0;
        #12;
        chk_req ("rst_bus_req", bus_req, '0);
        chk_own ("rst_owner", owner, OWNER_NONE);
        chk_bit ("rst_timeout", timeout_err, 1'b0);
        chk_bit ("rst_proto", proto_err, 1'b0);
        chk_resp("rst_if_resp", if_resp, '0);
        chk_resp("rst_mem_resp", mem_resp_out, '0);
        @(negedge clock) reset = 1'b1;

        // IF load, memory ready on the third BUSY cycle
        tick();
        rq_if  = mkreq(58'h40, 512'd0, 1'b1, 1'b0);
        if_req = rq_if;
        tick();
        chk_req("t1_bus_req", bus_req, rq_if);
        chk_own("t1_owner", owner, OWNER_IF);
        tick();
        tick();
        chk_req("t1_bus_req_held", bus_req, rq_if);
        dpat     = {64{8'hA5}};
        bus_resp = mkresp(dpat, 1'b1);
        #1;
        chk_resp("t1_if_resp", if_resp, mkresp(dpat, 1'b1));
        chk_resp("t1_mem_resp", mem_resp_out, '0);
        if_req = '0;
        tick();
        bus_resp = '0;
        #1;
        chk_req ("t1_bus_req_clr", bus_req, '0);
        chk_own ("t1_owner_clr", owner, OWNER_NONE);
        chk_resp("t1_if_resp_clr", if_resp, '0);

        // Both pending from reset: MEM, IF, MEM, IF, MEM, IF
        @(negedge clock) reset = 1'b0;
        @(negedge clock) reset = 1'b1;
        rq_if      = mkreq(58'h100, 512'd0, 1'b1, 1'b0);
        rq_mem     = mkreq(58'h200, 512'd0, 1'b1, 1'b0);
        if_req     = rq_if;
        mem_req_in = rq_mem;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_own("t2_owner", owner, (i % 2 == 0) ? OWNER_MEM : OWNER_IF);
            chk_req("t2_bus_req", bus_req, (i % 2 == 0) ? rq_mem : rq_if);
            dpat     = 512'(i + 1);
            bus_resp = mkresp(dpat, 1'b1);
            #1;
            chk_resp("t2_if_resp", if_resp, (i % 2 == 1) ? mkresp(dpat, 1'b1) : '0);
            chk_resp("t2_mem_resp", mem_resp_out, (i % 2 == 0) ? mkresp(dpat, 1'b1) : '0);
            tick();
            bus_resp = '0;
            #1;
            chk_req("t2_turnaround", bus_req, '0);
        end

        // MEM store held steady while IF changes address mid-BUSY
        dpat       = {16{32'hDEAD_BEEF}};
        rq_mem     = mkreq(58'h10, dpat, 1'b0, 1'b1);
        mem_req_in = rq_mem;
        tick();
        chk_req("t3_bus_req", bus_req, rq_mem);
        rq_if  = mkreq(58'h300, 512'd0, 1'b1, 1'b0);
        if_req = rq_if;
        tick();
        chk_req("t3_held1", bus_req, rq_mem);
        tick();
        chk_req("t3_held2", bus_req, rq_mem);
        bus_resp = mkresp({64{8'h3C}}, 1'b1);
        #1;
        chk_resp("t3_mem_resp", mem_resp_out, mkresp({64{8'h3C}}, 1'b1));
        chk_resp("t3_if_resp", if_resp, '0);
        mem_req_in = '0;
        tick();
        bus_resp = '0;
        #1;
        chk_own("t3_owner_idle", owner, OWNER_NONE);
        tick();
        chk_req("t3_if_new_addr", bus_req, rq_if);
        chk_own("t3_owner_if", owner, OWNER_IF);

        // 1-cycle memory with IF held: valid / zero alternating
        bus_resp = mkresp({64{8'hC3}}, 1'b1);
        #1;
        chk_resp("t4_if_ready", if_resp, mkresp({64{8'hC3}}, 1'b1));
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_req("t4_pattern", bus_req, (i % 2 == 0) ? mkreq(58'h0, 512'd0, 1'b0, 1'b0) : rq_if);
            chk_bit("t4_mem_no_ready", mem_resp_out.mem_ready, 1'b0);
        end
        if_req = '0;
        tick();
        bus_resp = '0;

        // Watchdog: memory silent for 9 BUSY cycles
        rq_if  = mkreq(58'h80, {16{32'h0F0F_1234}}, 1'b0, 1'b1);
        if_req = rq_if;
        tick();
        chk_bit("t5_to_start", timeout_err, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk_bit("t5_timeout", timeout_err, (i >= 8) ? 1'b1 : 1'b0);
        end
        chk_req("t5_bus_held", bus_req, rq_if);
        bus_resp = mkresp({64{8'h5A}}, 1'b1);
        #1;
        chk_resp("t5_if_resp", if_resp, mkresp({64{8'h5A}}, 1'b1));
        if_req = '0;
        tick();
        bus_resp = '0;
        #1;
        chk_req("t5_bus_clr", bus_req, '0);
        chk_bit("t5_sticky", timeout_err, 1'b1);

        // Asynchronous reset mid-BUSY, then a load+store conflict
        mem_req_in = mkreq(58'h20, 512'd0, 1'b1, 1'b0);
        tick();
        chk_own("t6_owner_mem", owner, OWNER_MEM);
        #2;
        reset = 1'b0;
        #1;
        chk_req("t6_async_bus", bus_req, '0);
        chk_own("t6_async_owner", owner, OWNER_NONE);
        chk_bit("t6_async_timeout", timeout_err, 1'b0);
        dpat       = {16{32'hEEEE_0001}};
        mem_req_in = mkreq(58'h30, dpat, 1'b1, 1'b1);
        #2;
        reset = 1'b1;
        tick();
        chk_req("t6_store_only", bus_req, mkreq(58'h30, dpat, 1'b0, 1'b1));
        chk_bit("t6_proto", proto_err, 1'b1);
        chk_own("t6_owner", owner, OWNER_MEM);
        bus_resp   = mkresp(512'd7, 1'b1);
        mem_req_in = '0;
        tick();
        bus_resp = '0;
        #1;
        chk_bit("t6_proto_sticky", proto_err, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
